vga_fb_arbiter: RTL

Sequences and shares the 80x60 VGA framebuffer write port between the CPU's memory-mapped pixel writes and a hardware rectangle-fill engine. It sits between the MMIO write decode and `vga_fb_driver_80x60`, and drives that driver's WE/WA/WD. CPU writes always win the port. The fill engine writes one pixel per free cycle and raises a one-cycle completion pulse that the wrapper can OR into the MCU interrupt.

---
 rtl/vga_fb_pkg.sv | 21 ++
 rtl/vga_fb_arbiter_fill_addr_gen.sv | 45 ++++
 rtl/vga_fb_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/vga_fb_pkg.sv
// Shared framebuffer geometry, fill FSM state type and address packing helper.
package vga_fb_pkg;

    localparam int unsigned FB_W = 80;
    localparam int unsigned FB_H = 60;
    localparam int unsigned XW   = 7;
    localparam int unsigned YW   = 6;
    localparam int unsigned AW   = XW + YW;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StFin
    } fill_state_t;

    // Framebuffer address is row-major: {y, x}.
    function automatic logic [AW-1:0] fb_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_fill_addr_gen.sv
// Row-major x/y scan counter for the rectangle-fill engine.
module fill_addr_gen #(
    parameter int unsigned XW = 7,
    parameter int unsigned YW = 6
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          load,
    input  logic          advance,
    input  logic [XW-1:0] start_x,
    input  logic [YW-1:0] start_y,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    assign last = (x_q == x1) && (y_q == y1);
    assign x    = x_q;
    assign y    = y_q;

    // Load the start corner, then step x with wrap to x0 and carry into y; hold at the last pixel.
    always_ff @(posedge CLK) begin
        if (RST) begin
            x_q <= '0;
            y_q <= '0;
        end else if (load) begin
            x_q <= start_x;
            y_q <= start_y;
        end else if (advance && !last) begin
            if (x_q == x1) begin
                x_q <= x0;
                y_q <= y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer write-port arbiter: CPU pixel writes always win, the rectangle-fill
// engine uses every free cycle. Optional macro VGA_FILL_CLIP_EN clamps oversized
// x1/y1 to the framebuffer edge instead of rejecting the fill.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int unsigned FB_W = vga_fb_pkg::FB_W,
    parameter int unsigned FB_H = vga_fb_pkg::FB_H,
    parameter int unsigned XW   = vga_fb_pkg::XW,
    parameter int unsigned YW   = vga_fb_pkg::YW
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CPU_WE,
    input  logic [XW+YW-1:0] CPU_WA,
    input  logic [7:0]       CPU_WD,
    input  logic             FILL_START,
    input  logic [XW-1:0]    FILL_X0,
    input  logic [XW-1:0]    FILL_X1,
    input  logic [YW-1:0]    FILL_Y0,
    input  logic [YW-1:0]    FILL_Y1,
    input  logic [7:0]       FILL_COLOR,
    output logic             FB_WE,
    output logic [XW+YW-1:0] FB_WA,
    output logic [7:0]       FB_WD,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    localparam logic [XW-1:0] XMAX = XW'(FB_W - 1);
    localparam logic [YW-1:0] YMAX = YW'(FB_H - 1);

    fill_state_t state_q, state_d;

    logic             fb_we_q, fb_we_d;
    logic [XW+YW-1:0] fb_wa_q, fb_wa_d;
    logic [7:0]       fb_wd_q, fb_wd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [XW-1:0] x0_q, x1_q;
    logic [YW-1:0] y1_q;
    logic [7:0]    color_q;
    logic          rej_q;

    logic [XW-1:0] x1_eff;
    logic [YW-1:0] y1_eff;
    logic          bad;
    logic          latch_en;
    logic          load;
    logic          advance;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic          last;

    // Validate the requested rectangle, clamping the far corner when clipping is built in.
    always_comb begin
        x1_eff = FILL_X1;
        y1_eff = FILL_Y1;
`ifdef VGA_FILL_CLIP_EN
        if (FILL_X1 > XMAX) x1_eff = XMAX;
        if (FILL_Y1 > YMAX) y1_eff = YMAX;
        bad = (FILL_X0 > x1_eff) || (FILL_Y0 > y1_eff) || (FILL_X0 > XMAX) || (FILL_Y0 > YMAX);
`else
        bad = (FILL_X0 > FILL_X1) || (FILL_Y0 > FILL_Y1) || (FILL_X1 > XMAX) || (FILL_Y1 > YMAX);
`endif
    end

    fill_addr_gen #(
        .XW(XW),
        .YW(YW)
    ) u_addr_gen (
        .CLK     (CLK),
        .RST     (RST),
        .load    (load),
        .advance (advance),
        .start_x (FILL_X0),
        .start_y (FILL_Y0),
        .x0      (x0_q),
        .x1      (x1_q),
        .y1      (y1_q),
        .x       (cur_x),
        .y       (cur_y),
        .last    (last)
    );

    // Next state and next registered outputs; a CPU write pre-empts the fill pixel this cycle.
    always_comb begin
        state_d  = state_q;
        fb_we_d  = CPU_WE;
        fb_wa_d  = CPU_WE ? CPU_WA : fb_wa_q;
        fb_wd_d  = CPU_WE ? CPU_WD : fb_wd_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q;
        latch_en = 1'b0;
        load     = 1'b0;
        advance  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (FILL_START) begin
                    latch_en = 1'b1;
                    if (bad) begin
                        state_d = StFin;
                    end else begin
                        err_d   = 1'b0;
                        load    = 1'b1;
                        busy_d  = 1'b1;
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                busy_d = 1'b1;
                if (!CPU_WE) begin
                    fb_we_d = 1'b1;
                    fb_wa_d = fb_addr(cur_x, cur_y);
                    fb_wd_d = color_q;
                    advance = 1'b1;
                    if (last) state_d = StFin;
                end
            end
            StFin: begin
                done_d  = 1'b1;
                if (rej_q) err_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            fb_we_q <= 1'b0;
            fb_wa_q <= '0;
            fb_wd_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fb_we_q <= fb_we_d;
            fb_wa_q <= fb_wa_d;
            fb_wd_q <= fb_wd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Capture bounds and color at an accepted-or-rejected start; later input changes are ignored.
    always_ff @(posedge CLK) begin
        if (RST) begin
            x0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            rej_q   <= 1'b0;
        end else if (latch_en) begin
            x0_q    <= FILL_X0;
            x1_q    <= x1_eff;
            y1_q    <= y1_eff;
            color_q <= FILL_COLOR;
            rej_q   <= bad;
        end
    end

    assign FB_WE = fb_we_q;
    assign FB_WA = fb_wa_q;
    assign FB_WD = fb_wd_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign ERR   = err_q;

endmodule
